// File: rtl/aes_rx_pkg.sv
// aes_rx_pkg: shared constants, collector state type and payload CRC helper
package aes_rx_pkg;
  localparam int BLOCK_W = 128;
  localparam int BLOCK_BYTES = 16;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_t;
  // MSB-first CRC over a right-aligned payload of BLOCK_W-cw bits, no reflection, no final xor
  function automatic logic [31:0] crc_calc(input logic [119:0] payload, input logic [31:0] poly,
                                           input logic [31:0] init, input int cw);
    logic [31:0] mask, top, crc;
    logic [119:0] p;
    logic fb;
    mask = (32'h1 << cw) - 32'h1;
    top = 32'h1 << (cw - 1);
    crc = init & mask;
    p = payload << (cw - 8);
    for (int i = 0; i < 120; i++) begin
      if (i < BLOCK_W - cw) begin
        fb = (|(crc & top)) ^ p[119];
        crc = ((crc << 1) ^ (fb ? poly : 32'h0)) & mask;
      end
      p = p << 1;
    end
    return crc;
  endfunction
endpackage

// File: rtl/aes_rx_fifo.sv
// aes_rx_fifo: first-word-fall-through FIFO with occupancy count
module aes_rx_fifo #(
  parameter int W = 113,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign do_wr = wr_en && (count != FULL);
  assign do_rd = rd_en && (count != '0);
  assign rd_data = mem[rp];
  // storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        mem[wp] <= wr_data;
        wp <= wp + 1'b1;
      end
      if (do_rd) rp <= rp + 1'b1;
      count <= count + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
    end
endmodule

// File: rtl/decipher.sv
// decipher: combinational block decipher core for the AES-over-UART link
module decipher #(
  parameter logic [127:0] KEY = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C
) (
  input  logic [127:0] ct,
  output logic [127:0] pt
);
  logic [127:0] x;
  assign x = ct ^ KEY;
  assign pt = {x[119:0], x[127:120]};
endmodule

// File: rtl/aes_rx_pipe.sv
// aes_rx_pipe: byte collector, decipher stage, CRC check and output FIFO for the UART link
module aes_rx_pipe
  import aes_rx_pkg::*;
#(
  parameter int          CRC_W       = 16,
  parameter logic [31:0] CRC_POLY    = 32'h0000_1021,
  parameter logic [31:0] CRC_INIT    = 32'h0000_FFFF,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic        DROP_BAD    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   crc_en,
  output logic [127-CRC_W:0]     out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   timeout,
  output logic [15:0]            good_cnt,
  output logic [15:0]            bad_cnt
);
  localparam int PW = BLOCK_W - CRC_W;
  localparam int IW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 2;
  state_t state;
  logic [3:0] idx;
  logic [IW-1:0] idle_q;
  logic [119:0] sh_q;
  logic [127:0] blk_q, pt_q, dec_pt;
  logic blk_v, blk_crc, pt_v, pt_crc, acc, to_fire, err, wr_en;
  logic [119:0] pay_ext;
  logic [31:0] crc_full;
  logic [PW:0] rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  assign in_ready = ({1'b0, fifo_count} + CW'(blk_v) + CW'(pt_v)) < CW'(FIFO_DEPTH);
  assign acc = in_valid && in_ready;
  assign to_fire = (TIMEOUT_CYC != 0) && (state == ST_COLLECT) && (idle_q == IW'(TIMEOUT_CYC));
  assign timeout = to_fire;
  // byte collector: shifts bytes in MSB-first, hands a full block to the pipeline, aborts stale partial blocks
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      idx <= '0;
      idle_q <= '0;
      sh_q <= '0;
      blk_q <= '0;
      blk_v <= 1'b0;
      blk_crc <= 1'b0;
    end else begin
      blk_v <= 1'b0;
      if (to_fire) begin
        state <= ST_IDLE;
        idx <= '0;
        idle_q <= '0;
      end else if (acc) begin
        sh_q <= {sh_q[111:0], in_data};
        idle_q <= '0;
        if (state == ST_IDLE) begin
          state <= ST_COLLECT;
          idx <= 4'd1;
        end else if (idx == 4'd15) begin
          state <= ST_IDLE;
          idx <= '0;
          blk_q <= {sh_q, in_data};
          blk_v <= 1'b1;
          blk_crc <= crc_en;
        end else idx <= idx + 4'd1;
      end else if (state == ST_COLLECT && idle_q != IW'(TIMEOUT_CYC)) idle_q <= idle_q + 1'b1;
    end
  decipher u_dec (.ct(blk_q), .pt(dec_pt));
  // decipher stage register, carrying the block's crc_en alongside it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pt_q <= '0;
      pt_v <= 1'b0;
      pt_crc <= 1'b0;
    end else begin
      pt_v <= blk_v;
      if (blk_v) begin
        pt_q <= dec_pt;
        pt_crc <= blk_crc;
      end
    end
  assign pay_ext = 120'(pt_q[127:CRC_W]);
  assign crc_full = crc_calc(pay_ext, CRC_POLY, CRC_INIT, CRC_W);
  assign err = pt_crc && (crc_full != 32'(pt_q[CRC_W-1:0]));
  assign wr_en = pt_v && !(err && DROP_BAD);
  // saturating frame counters; failed frames are counted even when dropped
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      good_cnt <= '0;
      bad_cnt <= '0;
    end else begin
      if (pt_v && !err && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      if (pt_v && err && bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
    end
  aes_rx_fifo #(.W(PW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data({err, pt_q[127:CRC_W]}),
    .rd_en(out_ready),
    .rd_data(rd_data),
    .count(fifo_count)
  );
  assign out_valid = fifo_count != '0;
  assign out_err = rd_data[PW];
  assign out_data = rd_data[PW-1:0];
endmodule

// File: tb/tb_aes_rx_pipe.sv
// tb_aes_rx_pipe: scoreboard bench for the receive pipeline, keep and drop policies side by side
module tb_aes_rx_pipe;
  localparam logic [127:0] KEY = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C;
  localparam logic [111:0] P0 = 112'h0123_4567_89AB_CDEF_0011_2233_4455;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, crc_en = 1'b1, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_err, out_valid, timeout;
  logic [111:0] out_data, d_out_data;
  logic [15:0] good_cnt, bad_cnt, d_good_cnt, d_bad_cnt;
  logic d_in_valid, d_in_ready, d_out_err, d_out_valid, d_timeout;
  logic [112:0] sb[$], dsb[$];
  logic [15:0] exp_good = 0, exp_bad = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign d_in_valid = in_valid && in_ready;

  aes_rx_pipe #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .crc_en(crc_en), .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .timeout(timeout), .good_cnt(good_cnt), .bad_cnt(bad_cnt));
  aes_rx_pipe #(.TIMEOUT_CYC(16), .DROP_BAD(1'b1)) dut_drop (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .crc_en(crc_en), .out_data(d_out_data), .out_err(d_out_err), .out_valid(d_out_valid),
    .out_ready(out_ready), .timeout(d_timeout), .good_cnt(d_good_cnt), .bad_cnt(d_bad_cnt));

  function automatic logic [15:0] crc16(input logic [111:0] p);
    logic [15:0] c = 16'hFFFF;
    for (int b = 0; b < 14; b++) begin
      c ^= {p[111:104], 8'h00};
      p = p << 8;
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [127:0] encipher(input logic [127:0] pt);
    logic [127:0] y;
    y = {pt[7:0], pt[127:8]};
    return y ^ KEY;
  endfunction

  // scoreboard pops for both instances, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pop_keep unexpected entry got=%h exp=none", {out_err, out_data});
      end else if ({out_err, out_data} !== sb[0]) begin
        failures++;
        $display("FAIL pop_keep got=%h exp=%h", {out_err, out_data}, sb[0]);
      end
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (!reset && d_out_valid && out_ready) begin
      checks++;
      if (dsb.size() == 0) begin
        failures++;
        $display("FAIL pop_drop unexpected entry got=%h exp=none", {d_out_err, d_out_data});
      end else if ({d_out_err, d_out_data} !== dsb[0]) begin
        failures++;
        $display("FAIL pop_drop got=%h exp=%h", {d_out_err, d_out_data}, dsb[0]);
      end
      if (dsb.size() != 0) void'(dsb.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_stuck got=0 exp=1 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [111:0] p, input logic [15:0] fld, input logic ce);
    logic [127:0] ct;
    logic e;
    e = ce && (crc16(p) != fld);
    sb.push_back({e, p});
    if (!e) dsb.push_back({1'b0, p});
    if (e) exp_bad++;
    else exp_good++;
    ct = encipher({p, fld});
    crc_en = ce;
    for (int i = 0; i < 16; i++) begin
      send_byte(ct[127:120]);
      ct = ct << 8;
    end
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 300 && (sb.size() != 0 || dsb.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0 || dsb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending keep=%0d drop=%0d exp=0", sb.size(), dsb.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_err, timeout, good_cnt, bad_cnt, out_data} !== {4'b1000, 32'h0, 112'h0}) begin
      failures++;
      $display("FAIL reset_keep got=%h exp=%h", {in_ready, out_valid, out_err, timeout, good_cnt, bad_cnt, out_data},
               {4'b1000, 32'h0, 112'h0});
    end
    checks++;
    if ({d_in_ready, d_out_valid, d_out_err, d_timeout, d_good_cnt, d_bad_cnt} !== {4'b1000, 32'h0}) begin
      failures++;
      $display("FAIL reset_drop got=%h exp=%h", {d_in_ready, d_out_valid, d_out_err, d_timeout, d_good_cnt, d_bad_cnt},
               {4'b1000, 32'h0});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    send_frame(P0, crc16(P0), 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_k1 out_valid got=%b exp=0", out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL lat_k2 out_valid got=%b exp=1", out_valid);
    end
    wait_drain();
    checks++;
    if ({good_cnt, bad_cnt, d_good_cnt, d_bad_cnt} !== {16'd1, 16'd0, 16'd1, 16'd0}) begin
      failures++;
      $display("FAIL single_cnt got=%h exp=%h", {good_cnt, bad_cnt, d_good_cnt, d_bad_cnt}, {16'd1, 16'd0, 16'd1, 16'd0});
    end
  endtask

  task automatic test_bad_crc;
    logic seen = 1'b0;
    logic [111:0] p = 112'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC;
    send_frame(p, crc16(p) ^ 16'h00FF, 1'b1);
    repeat (6) begin
      @(posedge clk);
      #1;
      seen |= d_out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL drop_no_valid got=%b exp=0", seen);
    end
    wait_drain();
    checks++;
    if ({good_cnt, bad_cnt, d_good_cnt, d_bad_cnt} !== {exp_good, exp_bad, exp_good, exp_bad}) begin
      failures++;
      $display("FAIL bad_cnt got=%h exp=%h", {good_cnt, bad_cnt, d_good_cnt, d_bad_cnt}, {exp_good, exp_bad, exp_good, exp_bad});
    end
  endtask

  task automatic test_bypass;
    logic [111:0] p = 112'h5555_AAAA_0F0F_F0F0_1357_9BDF_2468;
    send_frame(p, ~crc16(p), 1'b0);
    wait_drain();
    checks++;
    if ({good_cnt, bad_cnt, d_good_cnt, d_bad_cnt} !== {exp_good, exp_bad, exp_good, exp_bad}) begin
      failures++;
      $display("FAIL bypass_cnt got=%h exp=%h", {good_cnt, bad_cnt, d_good_cnt, d_bad_cnt}, {exp_good, exp_bad, exp_good, exp_bad});
    end
    crc_en = 1'b1;
  endtask

  task automatic test_timeout;
    int first = 0, n = 0, dn = 0;
    logic [111:0] p = 112'h0BAD_F00D_0000_1111_2222_3333_4444;
    for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i));
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk);
      #1;
      if (timeout) begin
        n++;
        if (first == 0) first = i;
      end
      if (d_timeout) dn++;
    end
    checks++;
    if (first != 16 || n != 1 || dn != 1) begin
      failures++;
      $display("FAIL timeout_pulse got first=%0d count=%0d drop_count=%0d exp first=16 count=1 drop_count=1", first, n, dn);
    end
    send_frame(p, crc16(p), 1'b1);
    wait_drain();
    checks++;
    if ({good_cnt, d_good_cnt} !== {exp_good, exp_good}) begin
      failures++;
      $display("FAIL timeout_cnt got=%h exp=%h", {good_cnt, d_good_cnt}, {exp_good, exp_good});
    end
  endtask

  task automatic test_back_to_back;
    logic [111:0] p;
    out_ready = 1'b0;
    fork
      for (int f = 0; f < 6; f++) begin
        p = {8'(f), 104'h11_2233_4455_6677_8899_AABB_CCDD} ^ {14{8'(f * 37)}};
        send_frame(p, crc16(p), 1'b1);
      end
      begin
        repeat (120) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
          failures++;
          $display("FAIL bp_ready got in_ready,out_valid=%b exp=01", {in_ready, out_valid});
        end
        checks++;
        if ({out_err, out_data} !== sb[0]) begin
          failures++;
          $display("FAIL bp_head got=%h exp=%h", {out_err, out_data}, sb[0]);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if ({good_cnt, d_good_cnt} !== {exp_good, exp_good}) begin
      failures++;
      $display("FAIL bp_cnt got=%h exp=%h", {good_cnt, d_good_cnt}, {exp_good, exp_good});
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] ct = encipher({P0, crc16(P0)});
    for (int i = 0; i < 10; i++) begin
      send_byte(ct[127:120]);
      ct = ct << 8;
    end
    reset = 1'b1;
    sb.delete();
    dsb.delete();
    exp_good = 0;
    exp_bad = 0;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_err, timeout, good_cnt, bad_cnt, out_data} !== {4'b1000, 32'h0, 112'h0}) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", {in_ready, out_valid, out_err, timeout, good_cnt, bad_cnt, out_data},
               {4'b1000, 32'h0, 112'h0});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_frame(P0, crc16(P0), 1'b1);
    wait_drain();
    checks++;
    if ({good_cnt, bad_cnt} !== 32'h0001_0000) begin
      failures++;
      $display("FAIL reset_mid_cnt got=%h exp=00010000", {good_cnt, bad_cnt});
    end
  endtask

  task automatic test_reset_pipe;
    logic seen = 1'b0;
    logic [111:0] p = 112'hFEDC_BA98_7654_3210_ABCD_EF01_2345;
    send_frame(p, crc16(p), 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    dsb.delete();
    exp_good = 0;
    exp_bad = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen |= out_valid | d_out_valid | (good_cnt != 0) | (d_good_cnt != 0);
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_pipe_flush got=%b exp=0", seen);
    end
    send_frame(P0, crc16(P0), 1'b1);
    wait_drain();
    checks++;
    if ({good_cnt, d_good_cnt} !== 32'h0001_0001) begin
      failures++;
      $display("FAIL reset_pipe_cnt got=%h exp=00010001", {good_cnt, d_good_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_crc();
    test_bypass();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_reset_pipe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
